cp_removal: RTL

CP_REMOVAL -- requirements
Module: cp_removal

---
 rtl/cp_pkg.sv | 21 ++
 rtl/cp_len_sel.sv | 18 +
 rtl/cp_removal.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cp_pkg.sv
// cp_pkg: constants and types shared by the CP removal and CP insertion blocks.
//   Slot geometry (FFT size, symbols per slot, the two CP lengths), the symbol
//   indices that carry the long CP, and the framing FSM state encoding.
package cp_pkg;

    localparam int CP_FFT_SIZE = 2048;
    localparam int CP_N_SYMB   = 14;
    localparam int CP_NCP1     = 160;
    localparam int CP_NCP2     = 144;

    // Symbols that carry the long cyclic prefix
    localparam logic [3:0] LONG_CP_SYM0 = 4'd0;
    localparam logic [3:0] LONG_CP_SYM1 = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CP_SKIP = 2'd1,
        ST_DATA    = 2'd2
    } cp_state_t;

endpackage

// File: rtl/cp_len_sel.sv
// cp_len_sel: maps a symbol index to its cyclic-prefix length (combinational).
//   i_symb : symbol index within the slot
//   o_ncp  : CP length for that symbol (NCP1 on long-CP symbols, else NCP2)
module cp_len_sel
    import cp_pkg::*;
#(
    parameter int NCP1 = CP_NCP1,
    parameter int NCP2 = CP_NCP2,
    parameter int CW   = 8
) (
    input  logic [3:0]    i_symb,
    output logic [CW-1:0] o_ncp
);

    assign o_ncp = (i_symb == LONG_CP_SYM0 || i_symb == LONG_CP_SYM1) ?
                   CW'(NCP1) : CW'(NCP2);

endmodule

// File: rtl/cp_removal.sv
// cp_removal: strips the cyclic prefix from each OFDM symbol of a slot and
// forwards the FFT_SIZE useful samples with symbol framing flags.
//   clk, rst          : clock (rising edge), asynchronous active-low reset
//   in_valid          : input sample qualifier; low cycles freeze all state
//   in_sof            : first CP sample of symbol 0 of a slot
//   in_r, in_i        : time-domain sample
//   out_valid         : output qualifier, one cycle after the forwarded input
//   out_r, out_i      : forwarded sample (held while out_valid is low)
//   out_sos, out_eos  : first / last useful sample of a symbol
//   out_symb          : symbol index of the output sample
//   slot_done         : pulse with the last useful sample of the slot
//   sync_err          : pulse when in_sof arrives while a slot is in progress
module cp_removal
    import cp_pkg::*;
#(
    parameter int WIDTH    = 26,
    parameter int FFT_SIZE = CP_FFT_SIZE,
    parameter int N_SYMB   = CP_N_SYMB,
    parameter int NCP1     = CP_NCP1,
    parameter int NCP2     = CP_NCP2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_r,
    input  logic [WIDTH-1:0] in_i,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_r,
    output logic [WIDTH-1:0] out_i,
    output logic             out_sos,
    output logic             out_eos,
    output logic [3:0]       out_symb,
    output logic             slot_done,
    output logic             sync_err
);

    localparam int MAXLEN = (FFT_SIZE > NCP1) ? ((FFT_SIZE > NCP2) ? FFT_SIZE : NCP2)
                                              : ((NCP1 > NCP2) ? NCP1 : NCP2);
    localparam int CNTW   = $clog2(MAXLEN + 1);

    cp_state_t       r_state;
    logic [CNTW-1:0] r_cnt;
    logic [3:0]      r_symb;

    logic [CNTW-1:0] w_ncp;
    logic [CNTW-1:0] w_ncp_m1;
    logic            w_last;
    logic            w_slot_end;

    cp_len_sel #(
        .NCP1 (NCP1),
        .NCP2 (NCP2),
        .CW   (CNTW)
    ) u_len (
        .i_symb (r_symb),
        .o_ncp  (w_ncp)
    );

    assign w_ncp_m1   = w_ncp - CNTW'(1);
    assign w_last     = (r_cnt == CNTW'(FFT_SIZE - 1));
    assign w_slot_end = (r_symb == 4'(N_SYMB - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_symb    <= '0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_i     <= '0;
            out_sos   <= 1'b0;
            out_eos   <= 1'b0;
            out_symb  <= '0;
            slot_done <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            // Flags are single-cycle; data and symbol index hold between outputs
            out_valid <= 1'b0;
            out_sos   <= 1'b0;
            out_eos   <= 1'b0;
            slot_done <= 1'b0;
            sync_err  <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (in_sof) begin
                            // This sample is CP sample 0 of symbol 0
                            r_state <= ST_CP_SKIP;
                            r_symb  <= '0;
                            r_cnt   <= CNTW'(1);
                        end
                    end
                    ST_CP_SKIP: begin
                        if (in_sof) begin
                            sync_err <= 1'b1;
                            r_symb   <= '0;
                            r_cnt    <= CNTW'(1);
                        end else if (r_cnt == w_ncp_m1) begin
                            r_state <= ST_DATA;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNTW'(1);
                        end
                    end
                    ST_DATA: begin
                        if (in_sof) begin
                            // Resync wins even on the slot's last useful sample
                            sync_err <= 1'b1;
                            r_state  <= ST_CP_SKIP;
                            r_symb   <= '0;
                            r_cnt    <= CNTW'(1);
                        end else begin
                            out_valid <= 1'b1;
                            out_r     <= in_r;
                            out_i     <= in_i;
                            out_symb  <= r_symb;
                            out_sos   <= (r_cnt == '0);
                            out_eos   <= w_last;
                            if (w_last) begin
                                r_cnt <= '0;
                                if (w_slot_end) begin
                                    slot_done <= 1'b1;
                                    r_state   <= ST_IDLE;
                                end else begin
                                    r_symb  <= r_symb + 4'd1;
                                    r_state <= ST_CP_SKIP;
                                end
                            end else begin
                                r_cnt <= r_cnt + CNTW'(1);
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
